// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, decodes START/RSTART/STOP/byte frames
// and queues decoded events in a small first-word-fallthrough FIFO.
//
// state | meaning
// IDLE  | bus free, waiting for a START condition
// BUSY  | between START and STOP/TIMEOUT, decoding 9-bit frames
module i2c_bus_monitor #(
  parameter int US      = 100,
  parameter int FILT    = 3,
  parameter int FIFO_AW = 3,
  parameter int TO_US   = 1000
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_type,
  output logic [7:0] evt_dat,
  output logic       evt_ack,
  output logic       evt_first,
  output logic       bus_busy,
  output logic       ovf,
  input  logic       clr_ovf
);
  localparam logic [2:0] EV_START   = 3'd0;
  localparam logic [2:0] EV_RSTART  = 3'd1;
  localparam logic [2:0] EV_STOP    = 3'd2;
  localparam logic [2:0] EV_BYTE    = 3'd3;
  localparam logic [2:0] EV_ABORT   = 3'd4;
  localparam logic [2:0] EV_TIMEOUT = 3'd5;

  localparam int FW     = $clog2(FILT + 1);
  localparam int TO_CYC = TO_US * US;
  localparam bit TO_EN  = (TO_CYC > 0);
  localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int TO_LD  = TO_EN ? TO_CYC - 1 : 0;
  localparam int DEPTH  = 2 ** FIFO_AW;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;

  logic [1:0]    scl_sync, sda_sync;
  logic [FW-1:0] scl_fcnt, sda_fcnt;
  logic          scl_f, sda_f, scl_d, sda_d;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_fcnt <= '0;
      sda_fcnt <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      if (scl_sync[1] == scl_f) scl_fcnt <= '0;
      else if (scl_fcnt == FW'(FILT - 1)) begin
        scl_f    <= scl_sync[1];
        scl_fcnt <= '0;
      end else scl_fcnt <= scl_fcnt + 1'b1;
      if (sda_sync[1] == sda_f) sda_fcnt <= '0;
      else if (sda_fcnt == FW'(FILT - 1)) begin
        sda_f    <= sda_sync[1];
        sda_fcnt <= '0;
      end else sda_fcnt <= sda_fcnt + 1'b1;
    end
  end

  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    sreg, sreg_n;
  logic          first, first_n, hi_seen, hi_n, bit_smp, smp_n;
  logic          pend_v, pend_v_n;
  logic [2:0]    pend_type, pend_type_n, ev;
  logic [TO_W-1:0] to_cnt;
  logic          scl_rise, scl_fall, start_c, stop_c, to_fire;
  logic          push;
  logic [12:0]   push_rec;

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & sda_d & ~sda_f;
  assign stop_c   = scl_f & ~sda_d & sda_f & (state == BUSY);
  assign to_fire  = TO_EN && (state == BUSY) && !scl_f && (to_cnt == '0);

  // A bit is sampled on SCL rise but only committed on the following SCL fall, so the
  // SCL-high phase that frames a STOP or repeated START never counts as data.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    sreg_n      = sreg;
    first_n     = first;
    hi_n        = hi_seen;
    smp_n       = bit_smp;
    pend_v_n    = 1'b0;
    pend_type_n = pend_type;
    push        = 1'b0;
    push_rec    = '0;
    ev          = EV_STOP;
    if (pend_v) begin
      push     = 1'b1;
      push_rec = {pend_type, 10'd0};
    end
    if (start_c || stop_c) begin
      ev   = start_c ? ((state == BUSY) ? EV_RSTART : EV_START) : EV_STOP;
      push = 1'b1;
      if (bitcnt != 4'd0) begin
        push_rec    = {EV_ABORT, sreg, 2'b00};
        pend_v_n    = 1'b1;
        pend_type_n = ev;
      end else begin
        push_rec = {ev, 10'd0};
      end
      state_n  = start_c ? BUSY : IDLE;
      bitcnt_n = '0;
      sreg_n   = '0;
      hi_n     = 1'b0;
      if (start_c) first_n = 1'b1;
    end else if (to_fire) begin
      push     = 1'b1;
      push_rec = {EV_TIMEOUT, 10'd0};
      state_n  = IDLE;
      bitcnt_n = '0;
      sreg_n   = '0;
      hi_n     = 1'b0;
    end else if (state == BUSY) begin
      if (scl_rise) begin
        hi_n  = 1'b1;
        smp_n = sda_f;
      end else if (scl_fall && hi_seen) begin
        hi_n = 1'b0;
        if (bitcnt == 4'd8) begin
          push     = 1'b1;
          push_rec = {EV_BYTE, sreg, ~bit_smp, first};
          first_n  = 1'b0;
          bitcnt_n = '0;
          sreg_n   = '0;
        end else begin
          sreg_n   = {sreg[6:0], bit_smp};
          bitcnt_n = bitcnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= IDLE;
      bitcnt    <= '0;
      sreg      <= '0;
      first     <= 1'b0;
      hi_seen   <= 1'b0;
      bit_smp   <= 1'b0;
      pend_v    <= 1'b0;
      pend_type <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      sreg      <= sreg_n;
      first     <= first_n;
      hi_seen   <= hi_n;
      bit_smp   <= smp_n;
      pend_v    <= pend_v_n;
      pend_type <= pend_type_n;
      if (state != BUSY || scl_f) to_cnt <= TO_W'(TO_LD);
      else if (to_cnt != '0)       to_cnt <= to_cnt - 1'b1;
    end
  end

  logic [12:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, pop, wr_en;
  logic [12:0]      head;

  assign evt_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop       = evt_valid & evt_ready;
  assign wr_en     = aresetn & push & (~full | pop);
  assign head      = evt_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  assign {evt_type, evt_dat, evt_ack, evt_first} = head;
  assign bus_busy  = (state == BUSY);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (clr_ovf)         ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Randomized bench for i2c_bus_monitor: drives I2C traffic on the pins, predicts the
// decoded event stream at transaction level and compares what the consumer pops.
module tb_i2c_bus_monitor;
  localparam int US      = 10;
  localparam int FILT    = 3;
  localparam int FIFO_AW = 3;
  localparam int TO_US   = 20;
  localparam int TO_CYC  = US * TO_US;
  localparam int H       = 6;
  localparam logic [2:0] T_START = 3'd0, T_RSTART = 3'd1, T_STOP = 3'd2;
  localparam logic [2:0] T_BYTE = 3'd3, T_ABORT = 3'd4, T_TIMEOUT = 3'd5;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid, evt_ack, evt_first, bus_busy, ovf;
  logic [2:0] evt_type;
  logic [7:0] evt_dat;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 1;
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];

  bit         m_busy = 1'b0;
  bit         m_first = 1'b0;
  int         m_bits = 0;
  logic [7:0] m_val = 8'h00;

  i2c_bus_monitor #(.US(US), .FILT(FILT), .FIFO_AW(FIFO_AW), .TO_US(TO_US)) dut (
    .clk(clk), .aresetn(aresetn), .scl_in(scl_in), .sda_in(sda_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_dat(evt_dat), .evt_ack(evt_ack), .evt_first(evt_first),
    .bus_busy(bus_busy), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void expect_evt(input logic [2:0] t, input logic [7:0] d,
                                     input logic a, input logic f);
    exp_q.push_back({t, d, a, f});
  endfunction

  // consumer: choose ready, then record the head that the next posedge will pop
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = 1'($urandom_range(0, 1));
    endcase
    if (aresetn && evt_valid && evt_ready)
      obs_q.push_back({evt_type, evt_dat, evt_ack, evt_first});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_start();
    if (!scl_in) begin
      sda_in = 1'b1; wt(H);
      scl_in = 1'b1; wt(H);
    end
    sda_in = 1'b0; wt(H);
    scl_in = 1'b0; wt(H);
    if (m_bits != 0) expect_evt(T_ABORT, m_val, 1'b0, 1'b0);
    expect_evt(m_busy ? T_RSTART : T_START, 8'h00, 1'b0, 1'b0);
    m_busy = 1'b1; m_first = 1'b1; m_bits = 0; m_val = 8'h00;
  endtask

  task automatic bus_stop();
    sda_in = 1'b0; wt(H);
    scl_in = 1'b1; wt(H);
    sda_in = 1'b1; wt(H);
    if (m_busy) begin
      if (m_bits != 0) expect_evt(T_ABORT, m_val, 1'b0, 1'b0);
      expect_evt(T_STOP, 8'h00, 1'b0, 1'b0);
    end
    m_busy = 1'b0; m_bits = 0; m_val = 8'h00;
  endtask

  task automatic bus_bit(input logic b);
    sda_in = b;    wt(H);
    scl_in = 1'b1; wt(H);
    scl_in = 1'b0; wt(H);
    if (m_busy) begin
      if (m_bits < 8) begin
        m_val = {m_val[6:0], b};
        m_bits++;
      end else begin
        expect_evt(T_BYTE, m_val, ~b, m_first);
        m_first = 1'b0; m_bits = 0; m_val = 8'h00;
      end
    end
  endtask

  task automatic bus_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_bit(~ack);
  endtask

  task automatic drain_cmp(input string tag);
    int guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    wt(20);
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int nb, k;
    wt(4);
    check("rst_valid", evt_valid, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_fields", {evt_type, evt_dat, evt_ack, evt_first}, 0);
    aresetn = 1'b1;
    wt(5);

    rdy_mode = 1;
    bus_start();
    check("t1_busy_on", bus_busy, 1);
    bus_byte(8'h76, 1'b1);
    bus_byte(8'haa, 1'b1);
    bus_stop();
    drain_cmp("t1");
    check("t1_busy_off", bus_busy, 0);

    bus_start();
    bus_byte(8'h77, 1'b1);
    bus_byte(8'h55, 1'b1);
    bus_byte(8'h56, 1'b0);
    bus_stop();
    drain_cmp("t2");

    bus_start();
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
    bus_start();
    bus_byte(8'($urandom), 1'b1);
    bus_stop();
    check("t3_abort_head", exp_q[1], {T_ABORT, 8'h05, 2'b00});
    drain_cmp("t3");

    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      bus_start();
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0) bus_start();
        bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 7);
        for (int b = 0; b < k; b++) bus_bit(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) bus_start();
      end
      bus_stop();
      drain_cmp($sformatf("rnd%0d", it));
      check("rnd_busy", bus_busy, 32'(m_busy));
    end

    rdy_mode = 0;
    wt(2);
    bus_start();
    for (int j = 0; j < 7; j++) bus_byte(8'($urandom), 1'b1);
    bus_stop();
    while (exp_q.size() > 2 ** FIFO_AW) void'(exp_q.pop_back());
    wt(10);
    check("t4_ovf_set", ovf, 1);
    check("t4_valid", evt_valid, 1);
    check("t4_head_type", evt_type, T_START);
    rdy_mode = 1;
    drain_cmp("t4");
    check("t4_ovf_held", ovf, 1);
    clr_ovf = 1'b1; wt(1);
    clr_ovf = 1'b0; wt(1);
    check("t4_ovf_clr", ovf, 0);

    sda_in = 1'b0; wt(1);
    sda_in = 1'b1; wt(H);
    scl_in = 1'b0; wt(2);
    scl_in = 1'b1; wt(H);
    check("t5_idle_busy", bus_busy, 0);
    bus_start();
    scl_in = 1'b1; wt(2);
    scl_in = 1'b0; wt(H);
    bus_byte(8'h3c, 1'b1);
    bus_stop();
    drain_cmp("t5");

    rdy_mode = 0;
    wt(2);
    bus_start();
    bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b0);
    wt(2);
    check("t6_prerst_valid", evt_valid, 1);
    aresetn = 1'b0;
    scl_in = 1'b1; sda_in = 1'b1;
    wt(4);
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_busy", bus_busy, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_fields", {evt_type, evt_dat, evt_ack, evt_first}, 0);
    aresetn = 1'b1;
    exp_q.delete(); obs_q.delete();
    m_busy = 1'b0; m_bits = 0; m_val = 8'h00;
    rdy_mode = 1;
    wt(H);
    scl_in = 1'b0; wt(H);
    bus_byte(8'($urandom), 1'b1);
    bus_stop();
    drain_cmp("t6_idle");
    check("t6_idle_busy", bus_busy, 0);

    bus_start();
    wt(120);
    bus_byte(8'h9e, 1'b0);
    bus_stop();
    drain_cmp("t6_near");

    bus_start();
    wt(TO_CYC + 60);
    expect_evt(T_TIMEOUT, 8'h00, 1'b0, 1'b0);
    m_busy = 1'b0; m_bits = 0; m_val = 8'h00;
    check("t6_to_busy", bus_busy, 0);
    scl_in = 1'b1; wt(H);
    sda_in = 1'b1; wt(H);
    drain_cmp("t6_to");
    check("t6_to_idle", bus_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
